// File: rtl/imem_fetch_responder.sv
// Byte-addressed instruction memory with a byte-serial fetch sequencer and a valid/ready response channel.
// Define IMEM_MISALIGN_CHECK_EN to reject misaligned fetches with rsp_err instead of reading them.
module imem_fetch_responder #(
  parameter int ADDR_W      = 10,
  parameter int FETCH_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;

  localparam logic [1:0] LAST_CNT = 2'(FETCH_BYTES - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       addr_q, addr_d;
  logic [ADDR_W-1:0] rd_idx;
  logic [7:0]        rd_byte;
  logic              misaligned;

  logic [7:0] mem [2**ADDR_W];

  // Single-ported array: a load owns the port, so the sequencer stalls on ld_en.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign rd_idx  = idx_q + ADDR_W'(cnt_q);
  assign rd_byte = mem[rd_idx];

`ifdef IMEM_MISALIGN_CHECK_EN
  logic err_q, err_d;
  assign misaligned = |req_addr[1:0];
  assign rsp_err    = err_q;
`else
  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = misaligned ? RESP : READ;
      READ:    if (!ld_en && cnt_q == LAST_CNT) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    data_d = data_q;
    addr_d = addr_q;
`ifdef IMEM_MISALIGN_CHECK_EN
    err_d  = err_q;
`endif
    if (state_q == IDLE && req_valid) begin
      cnt_d  = '0;
      idx_d  = req_addr[ADDR_W-1:0];
      data_d = '0;
      addr_d = req_addr;
`ifdef IMEM_MISALIGN_CHECK_EN
      err_d  = misaligned;
`endif
    end else if (state_q == READ && !ld_en) begin
      data_d[{cnt_q, 3'b000} +: 8] = rd_byte;
      cnt_d = 2'(cnt_q + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
`ifdef IMEM_MISALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      addr_q <= addr_d;
`ifdef IMEM_MISALIGN_CHECK_EN
      err_q  <= err_d;
`endif
    end
  end

  assign rsp_data = data_q;
  assign rsp_addr = addr_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder; inputs driven and outputs sampled on negedge.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

`ifdef IMEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  imem_fetch_responder #(.ADDR_W(10), .FETCH_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Writes a little-endian word as four byte loads starting at index a (wrapping).
  task automatic load4(input logic [9:0] a, input logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a + 10'(k);
      ld_data = w[8*k +: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One fetch: n counts posedges after the accept edge; ld_cyc injects a load at that n.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                       input int exp_lat, input logic exp_err, input int hold,
                       input int ld_cyc, input logic [9:0] ld_a, input logic [7:0] ld_d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b0;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    while (!rsp_valid && n < 20) begin
      ld_en   = (n == ld_cyc);
      ld_addr = ld_a;
      ld_data = ld_d;
      @(negedge clk);
      n++;
    end
    ld_en = 1'b0;
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".data"}, rsp_data, exp_d);
    chk({tag, ".addr"}, rsp_addr, a);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      ld_en   = (n == ld_cyc);
      ld_addr = ld_a;
      ld_data = ld_d;
      @(negedge clk);
      n++;
      ld_en = 1'b0;
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_data"}, rsp_data, exp_d);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #12;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_data", rsp_data, 32'd0);
    chk("rst.rsp_addr", rsp_addr, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch
    load4(10'h000, 32'h0050_0513);
    fetch("t1", 32'h0, 32'h0050_0513, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    // Wrap-around: bytes 0x3FF,0x000,0x001,0x002
    load4(10'h3FF, 32'hDDCC_BBAA);
    fetch("t2", 32'h0000_03FF, MIS ? 32'h0 : 32'hDDCC_BBAA, MIS ? 0 : 4, MIS, 0, -1, 10'h0, 8'h0);
    fetch("t2u", 32'hABCD_0000, 32'h00DD_CCBB, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    // Backpressure; a load in RESP must not disturb the latched word
    load4(10'h008, 32'h4433_2211);
    fetch("t3", 32'h8, 32'h4433_2211, 4, 1'b0, 5, 5, 10'h008, 8'hEE);
    fetch("t3b", 32'h8, 32'h4433_22EE, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    // Load collision in the second READ cycle stalls by one cycle
    load4(10'h010, 32'h0010_0093);
    load4(10'h020, 32'h0302_0100);
    fetch("t4", 32'h10, 32'h0010_0093, 5, 1'b0, 0, 1, 10'h020, 8'h5A);
    fetch("t4b", 32'h20, 32'h0302_015A, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    // Asynchronous reset mid-READ
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5.rsp_data", rsp_data, 32'd0);
    chk("t5.rsp_addr", rsp_addr, 32'd0);
    chk("t5.busy", 32'(busy), 32'd0);
    chk("t5.req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    fetch("t5b", 32'h10, 32'h0010_0093, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    // Misaligned fetch: bytes 6..9 = 66 77 EE 22
    load4(10'h004, 32'h7766_0000);
    fetch("t6", 32'h6, MIS ? 32'h0 : 32'h22EE_7766, MIS ? 0 : 4, MIS, 0, -1, 10'h0, 8'h0);
    fetch("t6b", 32'h0, 32'h00DD_CCBB, 4, 1'b0, 0, -1, 10'h0, 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
